// File: rtl/fu_wb_queue.sv
// fu_wb_queue: per-functional-unit result queue feeding the writeback arbiter.
// Holds results while the arbiter stalls this unit and keeps them in completion order.
// Kills queued results on branch mispredict and clears resolved branch bits.
// Pushback (in_ready) comes only from registered occupancy.
//
// Packet layout, MSB first: {valid, br_bmask[BMASK_W], rob_idx[6], rd[5], data[32]}
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   in_pkt        FU result; in_pkt.valid requests an enqueue
//   in_ready      queue can accept in_pkt this cycle (not full)
//   out_pkt       head result to the arbiter; out_pkt.valid means presenting
//   wb_stall      arbiter did not take out_pkt this cycle
//   br_resolve    a branch resolved this cycle
//   br_mispred    the resolving branch was mispredicted
//   br_bit        one-hot tag of the resolving branch
//   flush         global kill: empty the queue
//   count         occupied entries, live and dead
module fu_wb_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned BMASK_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BMASK_W+43:0]        in_pkt,
    output logic                       in_ready,
    output logic [BMASK_W+43:0]        out_pkt,
    input  logic                       wb_stall,
    input  logic                       br_resolve,
    input  logic                       br_mispred,
    input  logic [BMASK_W-1:0]         br_bit,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic               valid;
        logic [BMASK_W-1:0] br_bmask;
        logic [5:0]         rob_idx;
        logic [4:0]         rd;
        logic [31:0]        data;
    } wb_pkt_t;

    wb_pkt_t            mem_q [DEPTH];
    logic [DEPTH-1:0]   live_q;
    logic [PtrW-1:0]    head_q;
    logic [PtrW-1:0]    tail_q;
    logic [CntW-1:0]    count_q;

    wb_pkt_t            in_p;
    wb_pkt_t            head_p;
    wb_pkt_t            out_p;
    wb_pkt_t            wr_p;
    logic               empty;
    logic               full;
    logic               mispred_now;
    logic               head_kill;
    logic               in_kill;
    logic [BMASK_W-1:0] clr_mask;
    logic               out_valid;
    logic               pop;
    logic               push;

    always_comb begin
        in_p        = wb_pkt_t'(in_pkt);
        head_p      = mem_q[head_q];
        empty       = (count_q == '0);
        full        = (count_q == CntW'(DEPTH));
        mispred_now = br_resolve & br_mispred;
        clr_mask    = br_resolve ? br_bit : '0;
        head_kill   = mispred_now & (|(head_p.br_bmask & br_bit));
        in_kill     = mispred_now & (|(in_p.br_bmask & br_bit));
        out_valid   = ~empty & live_q[head_q] & ~head_kill;

        out_p          = head_p;
        out_p.valid    = out_valid;
        out_p.br_bmask = head_p.br_bmask & ~clr_mask;

        // A non-empty head that is not presentable is dead and drains regardless of stall.
        pop  = ~empty & (~out_valid | ~wb_stall);
        // in_ready is derived from registered count only, so a full queue refuses even on pop.
        push = in_p.valid & ~full & ~flush & ~in_kill;

        wr_p          = in_p;
        wr_p.br_bmask = in_p.br_bmask & ~clr_mask;
    end

    assign in_ready = ~full;
    assign out_pkt  = out_p;
    assign count    = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            // Unoccupied slots are updated too; they are overwritten on push, so it is harmless.
            for (int i = 0; i < DEPTH; i++) begin
                if (br_resolve) begin
                    if (br_mispred) begin
                        live_q[i] <= live_q[i] & ~(|(mem_q[i].br_bmask & br_bit));
                    end else begin
                        mem_q[i].br_bmask <= mem_q[i].br_bmask & ~br_bit;
                    end
                end
            end
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
            end
            if (push) begin
                mem_q[tail_q]  <= wr_p;
                live_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_fu_wb_queue.sv
// Directed self-checking bench for fu_wb_queue (DEPTH=4, BMASK_W=4).
module tb_fu_wb_queue;

    localparam int unsigned B  = 4;
    localparam int unsigned PW = B + 44;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] in_pkt;
    logic          in_ready;
    logic [PW-1:0] out_pkt;
    logic          wb_stall;
    logic          br_resolve;
    logic          br_mispred;
    logic [B-1:0]  br_bit;
    logic          flush;
    logic [2:0]    count;

    int total;
    int bad;

    fu_wb_queue #(.DEPTH(4), .BMASK_W(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_pkt     (in_pkt),
        .in_ready   (in_ready),
        .out_pkt    (out_pkt),
        .wb_stall   (wb_stall),
        .br_resolve (br_resolve),
        .br_mispred (br_mispred),
        .br_bit     (br_bit),
        .flush      (flush),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input logic v, input logic [B-1:0] bm,
                                         input logic [5:0] rob);
        logic [4:0]  rd;
        logic [31:0] data;
        rd   = rob[4:0];
        data = {26'h0, rob} ^ 32'hA5A5_0000;
        return {v, bm, rob, rd, data};
    endfunction

    function automatic logic o_valid();
        return out_pkt[PW-1];
    endfunction

    function automatic logic [B-1:0] o_bmask();
        return out_pkt[PW-2 -: B];
    endfunction

    function automatic logic [5:0] o_rob();
        return out_pkt[42:37];
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_pkt     = '0;
        wb_stall   = 1'b0;
        br_resolve = 1'b0;
        br_mispred = 1'b0;
        br_bit     = '0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total++;
        if (count !== 3'd0 || o_valid() !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: count=%0d valid=%b in_ready=%b want 0/0/1",
                     count, o_valid(), in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 5; k++) begin
            in_pkt = (k <= 4) ? mk(1'b1, 4'b0000, 6'(k)) : '0;
            #1;
            if (k > 1) begin
                total++;
                if (o_valid() !== 1'b1 || o_rob() !== 6'(k - 1) || count !== 3'd1) begin
                    bad++;
                    $display("FAIL b2b_out%0d: valid=%b rob=%0d count=%0d want 1/%0d/1",
                             k - 1, o_valid(), o_rob(), count, k - 1);
                end
            end
            tick();
        end
        total++;
        if (o_valid() !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL b2b_drained: valid=%b count=%0d want 0/0", o_valid(), count);
        end
    endtask

    task automatic test_full_stall();
        wb_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_pkt = mk(1'b1, 4'b0000, 6'(10 + i));
            #1;
            total++;
            if (in_ready !== (i < 4)) begin
                bad++;
                $display("FAIL full_ready%0d: in_ready=%b want %b", i, in_ready, (i < 4));
            end
            tick();
        end
        in_pkt = '0;
        #1;
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_count: count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        wb_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            // Offer a packet while full and popping: must be refused.
            in_pkt = (k == 0) ? mk(1'b1, 4'b0000, 6'd63) : '0;
            #1;
            total++;
            if (o_valid() !== 1'b1 || o_rob() !== 6'(10 + k)) begin
                bad++;
                $display("FAIL full_drain%0d: valid=%b rob=%0d want 1/%0d",
                         k, o_valid(), o_rob(), 10 + k);
            end
            tick();
            if (k == 0) begin
                total++;
                if (in_ready !== 1'b1 || count !== 3'd3) begin
                    bad++;
                    $display("FAIL full_first_pop: in_ready=%b count=%0d want 1/3",
                             in_ready, count);
                end
            end
        end
        in_pkt = '0;
        total++;
        if (count !== 3'd0 || o_valid() !== 1'b0) begin
            bad++;
            $display("FAIL full_empty: count=%0d valid=%b want 0/0", count, o_valid());
        end
    endtask

    task automatic test_mispredict_kill();
        logic [B-1:0] bms [3];
        bms[0] = 4'b0001;
        bms[1] = 4'b0010;
        bms[2] = 4'b0001;
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pkt = mk(1'b1, bms[i], 6'(20 + i));
            tick();
        end
        in_pkt     = '0;
        wb_stall   = 1'b0;
        br_resolve = 1'b1;
        br_mispred = 1'b1;
        br_bit     = 4'b0001;
        #1;
        total++;
        if (o_valid() !== 1'b0) begin
            bad++;
            $display("FAIL kill_head_same_cycle: valid=%b want 0", o_valid());
        end
        tick();
        br_resolve = 1'b0;
        br_mispred = 1'b0;
        br_bit     = '0;
        #1;
        total++;
        if (o_valid() !== 1'b1 || o_rob() !== 6'd21 || count !== 3'd2) begin
            bad++;
            $display("FAIL kill_survivor: valid=%b rob=%0d count=%0d want 1/21/2",
                     o_valid(), o_rob(), count);
        end
        tick();
        total++;
        if (o_valid() !== 1'b0 || count !== 3'd1) begin
            bad++;
            $display("FAIL kill_dead_tail: valid=%b count=%0d want 0/1", o_valid(), count);
        end
        tick();
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL kill_drained: count=%0d want 0", count);
        end
    endtask

    task automatic test_correct_resolve();
        wb_stall = 1'b1;
        in_pkt   = mk(1'b1, 4'b0011, 6'd30);
        tick();
        in_pkt     = '0;
        br_resolve = 1'b1;
        br_mispred = 1'b0;
        br_bit     = 4'b0010;
        #1;
        total++;
        if (o_valid() !== 1'b1 || o_bmask() !== 4'b0001) begin
            bad++;
            $display("FAIL resolve_same_cycle: valid=%b bmask=%b want 1/0001",
                     o_valid(), o_bmask());
        end
        tick();
        br_resolve = 1'b0;
        br_bit     = '0;
        #1;
        total++;
        if (o_valid() !== 1'b1 || o_bmask() !== 4'b0001 || o_rob() !== 6'd30) begin
            bad++;
            $display("FAIL resolve_stored: valid=%b bmask=%b rob=%0d want 1/0001/30",
                     o_valid(), o_bmask(), o_rob());
        end
        wb_stall = 1'b0;
        tick();
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL resolve_drain: count=%0d want 0", count);
        end
    endtask

    task automatic test_push_mispred_flush();
        wb_stall   = 1'b1;
        in_pkt     = mk(1'b1, 4'b0100, 6'd40);
        br_resolve = 1'b1;
        br_mispred = 1'b1;
        br_bit     = 4'b0100;
        tick();
        br_resolve = 1'b0;
        br_mispred = 1'b0;
        br_bit     = '0;
        in_pkt     = '0;
        total++;
        if (count !== 3'd0 || o_valid() !== 1'b0) begin
            bad++;
            $display("FAIL push_killed: count=%0d valid=%b want 0/0", count, o_valid());
        end
        in_pkt = mk(1'b1, 4'b0000, 6'd41);
        tick();
        in_pkt = mk(1'b1, 4'b0000, 6'd42);
        tick();
        total++;
        if (count !== 3'd2) begin
            bad++;
            $display("FAIL flush_prefill: count=%0d want 2", count);
        end
        in_pkt = mk(1'b1, 4'b0000, 6'd43);
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        in_pkt = '0;
        total++;
        if (count !== 3'd0 || o_valid() !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_state: count=%0d valid=%b in_ready=%b want 0/0/1",
                     count, o_valid(), in_ready);
        end
        wb_stall = 1'b0;
    endtask

    task automatic test_async_reset_midstream();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pkt = mk(1'b1, 4'b0000, 6'(50 + i));
            tick();
        end
        in_pkt = '0;
        total++;
        if (count !== 3'd3 || o_valid() !== 1'b1) begin
            bad++;
            $display("FAIL midreset_fill: count=%0d valid=%b want 3/1", count, o_valid());
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || o_valid() !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_async: count=%0d valid=%b in_ready=%b want 0/0/1",
                     count, o_valid(), in_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        wb_stall = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_mispredict_kill();
        test_correct_resolve();
        test_push_mispred_flush();
        test_async_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
